// File: rtl/text_console_writer.sv
// Text console writer: turns a byte stream into text RAM writes,
// tracks the cursor and scrolls via a row-offset register.
module text_console_writer #(
  parameter int          COLS   = 50,
  parameter int          ROWS   = 37,
  parameter int          ADDR_W = 11,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [7:0]        char_in,
  input  logic              char_valid_in,
  output logic              char_ready_out,
  input  logic              clear_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out,
  output logic [5:0]        cursor_col_out,
  output logic [5:0]        cursor_row_out,
  output logic [5:0]        scroll_row_out,
  output logic              busy_out
);

  localparam int TOTAL = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_FILL = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(COLS - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_EXEC,
    S_LINECLR
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] fill_q;
  logic [ADDR_W-1:0] line_base_q;
  logic [5:0]        col_q, row_q, scroll_q;
  logic [7:0]        char_q;
  logic              clr_pend_q;
  logic              accept, do_nl;

  logic is_print, is_cr, is_lf, is_bs, is_ff;
  logic in_print;
  logic [5:0] scroll_inc;
  logic [ADDR_W-1:0] cur_addr, bs_addr;

  // Logical (row, col) to RAM address through the scroll offset.
  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [5:0] r,
    input logic [5:0] s,
    input logic [5:0] c
  );
    logic [6:0] sum;
    sum = {1'b0, r} + {1'b0, s};
    if (sum >= 7'(ROWS))
      sum = sum - 7'(ROWS);
    return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  assign is_print = (char_q >= 8'h20) && (char_q <= 8'h7E);
  assign is_cr    = (char_q == 8'h0D);
  assign is_lf    = (char_q == 8'h0A);
  assign is_bs    = (char_q == 8'h08);
  assign is_ff    = (char_q == 8'h0C);
  assign in_print = (char_in >= 8'h20) && (char_in <= 8'h7E);

  assign scroll_inc = (scroll_q == LAST_ROW) ? 6'd0 : scroll_q + 6'd1;
  assign cur_addr   = addr_of(row_q, scroll_q, col_q);
  assign bs_addr    = addr_of(row_q, scroll_q, col_q - 6'd1);

  assign char_ready_out = rst_n_in && (state_q == S_IDLE) && !clear_in;
  assign busy_out = !rst_n_in || (state_q == S_CLEAR) ||
                    (state_q == S_LINECLR);

  assign cursor_col_out = col_q;
  assign cursor_row_out = row_q;
  assign scroll_row_out = scroll_q;

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in)
      state_q <= S_CLEAR;
    else
      state_q <= state_d;
  end

  // Next state, accept strobe and newline decision.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    do_nl   = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        if (fill_q == LAST_FILL)
          state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clear_in) begin
          state_d = S_CLEAR;
        end else if (char_valid_in) begin
          accept  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          is_print: do_nl = (col_q == LAST_COL);
          is_lf:    do_nl = 1'b1;
          default:  do_nl = 1'b0;
        endcase
        if (do_nl)
          state_d = S_LINECLR;
        else if (is_ff || clr_pend_q || clear_in)
          state_d = S_CLEAR;
        else
          state_d = S_IDLE;
      end
      S_LINECLR: begin
        if (fill_q == LAST_LINE)
          state_d = (clr_pend_q || clear_in) ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Datapath: RAM write port, fill counter, cursor and scroll.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_en_out   <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= 8'h00;
      fill_q      <= '0;
      line_base_q <= '0;
      col_q       <= 6'd0;
      row_q       <= 6'd0;
      scroll_q    <= 6'd0;
      char_q      <= 8'h00;
      clr_pend_q  <= 1'b0;
    end else begin
      wr_en_out <= 1'b0;
      unique case (state_q)
        S_CLEAR: begin
          wr_en_out   <= 1'b1;
          wr_addr_out <= fill_q;
          wr_data_out <= BLANK;
          if (fill_q == LAST_FILL) begin
            fill_q     <= '0;
            col_q      <= 6'd0;
            row_q      <= 6'd0;
            scroll_q   <= 6'd0;
            clr_pend_q <= 1'b0;
          end else begin
            fill_q <= fill_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            char_q <= char_in;
            if (in_print) begin
              wr_en_out   <= 1'b1;
              wr_addr_out <= cur_addr;
              wr_data_out <= char_in;
            end else if (char_in == 8'h08 && col_q != 6'd0) begin
              wr_en_out   <= 1'b1;
              wr_addr_out <= bs_addr;
              wr_data_out <= BLANK;
            end
          end
        end
        S_EXEC: begin
          if (clear_in)
            clr_pend_q <= 1'b1;
          unique case (1'b1)
            is_print: col_q <= (col_q == LAST_COL) ? 6'd0 : col_q + 6'd1;
            is_cr:    col_q <= 6'd0;
            is_bs:    if (col_q != 6'd0) col_q <= col_q - 6'd1;
            default:  ;
          endcase
          if (do_nl) begin
            if (row_q < LAST_ROW) begin
              row_q       <= row_q + 6'd1;
              line_base_q <= addr_of(row_q + 6'd1, scroll_q, 6'd0);
            end else begin
              scroll_q    <= scroll_inc;
              line_base_q <= addr_of(LAST_ROW, scroll_inc, 6'd0);
            end
          end
        end
        S_LINECLR: begin
          if (clear_in)
            clr_pend_q <= 1'b1;
          wr_en_out   <= 1'b1;
          wr_addr_out <= line_base_q + fill_q;
          wr_data_out <= BLANK;
          if (fill_q == LAST_LINE)
            fill_q <= '0;
          else
            fill_q <= fill_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: random byte stream against a
// screen-level model, writes checked by a scoreboard monitor.
module tb_text_console_writer;

  localparam int COLS  = 50;
  localparam int ROWS  = 37;
  localparam int TOTAL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        clear;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  cur_col, cur_row, scroll_row;
  logic        busy;

  always #5 clk = ~clk;

  text_console_writer dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .char_in(char_in),
    .char_valid_in(char_valid),
    .char_ready_out(char_ready),
    .clear_in(clear),
    .wr_en_out(wr_en),
    .wr_addr_out(wr_addr),
    .wr_data_out(wr_data),
    .cursor_col_out(cur_col),
    .cursor_row_out(cur_row),
    .scroll_row_out(scroll_row),
    .busy_out(busy)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_col, m_row, m_scroll;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_wr(input int addr, input int data);
    exp_q.push_back(addr * 256 + data);
  endfunction

  function automatic int cur_addr();
    return ((m_row + m_scroll) % ROWS) * COLS + m_col;
  endfunction

  function automatic void push_clear();
    for (int i = 0; i < TOTAL; i++) push_wr(i, 32);
    m_col = 0;
    m_row = 0;
    m_scroll = 0;
  endfunction

  function automatic void push_newline();
    int base;
    if (m_row < ROWS - 1) m_row++;
    else m_scroll = (m_scroll + 1) % ROWS;
    base = ((m_row + m_scroll) % ROWS) * COLS;
    for (int i = 0; i < COLS; i++) push_wr(base + i, 32);
  endfunction

  // Returns the number of cycles the writer stays not-ready.
  function automatic int model_byte(input int c);
    if (c >= 32 && c <= 126) begin
      push_wr(cur_addr(), c);
      if (m_col < COLS - 1) begin
        m_col++;
        return 1;
      end
      m_col = 0;
      push_newline();
      return 1 + COLS;
    end
    case (c)
      13: m_col = 0;
      10: begin
        push_newline();
        return 1 + COLS;
      end
      8: if (m_col > 0) begin
        m_col--;
        push_wr(cur_addr(), 32);
      end
      12: begin
        push_clear();
        return 1 + TOTAL;
      end
      default: ;
    endcase
    return 1;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr %0d data %0h", wr_addr, wr_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(wr_addr) != e / 256 || int'(wr_data) != e % 256) begin
          errors++;
          $display("FAIL write actual %0d/%0h expected %0d/%0h",
                   wr_addr, wr_data, e / 256, e % 256);
        end
      end
    end
  end

  task automatic wait_idle(output int n, input int limit);
    n = 0;
    @(negedge clk);
    while (char_ready !== 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
    if (n >= limit) check("idle_timeout", n, -1);
  endtask

  task automatic check_state(input string tag);
    #1;
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_col"}, int'(cur_col), m_col);
    check({tag, "_row"}, int'(cur_row), m_row);
    check({tag, "_scroll"}, int'(scroll_row), m_scroll);
  endtask

  task automatic check_reset_outs();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_addr", int'(wr_addr), 0);
    check("rst_data", int'(wr_data), 0);
    check("rst_ready", int'(char_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_cursor", int'({cur_row, cur_col}), 0);
    check("rst_scroll", int'(scroll_row), 0);
  endtask

  task automatic send(input int c);
    int lat, n;
    @(posedge clk);
    #1;
    char_in = 8'(c);
    char_valid = 1'b1;
    @(negedge clk);
    check("ready_before_accept", int'(char_ready), 1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    lat = model_byte(c);
    wait_idle(n, lat + 5);
    check("latency", n, lat);
    check_state("send");
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    char_in = 8'h00;
    char_valid = 1'b0;
    clear = 1'b0;
    m_col = 0;
    m_row = 0;
    m_scroll = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs();

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_clear();
    wait_idle(n, 3000);
    check("init_fill_cycles", n, TOTAL);
    check("init_busy", int'(busy), 0);
    check_state("init");

    send(8'h41);
    send(8'h0D);
    for (int i = 0; i < COLS + 1; i++) send(8'h61 + (i % 26));
    for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
    check("at_last_row", m_row, ROWS - 1);
    send(8'h0A);
    send(8'h0D);
    send(8'h5A);
    send(8'h0D);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    send(8'h08);
    send(8'h0D);
    send(8'h08);
    send(8'h0C);

    // Clear wins over a simultaneous valid byte.
    @(posedge clk);
    #1;
    char_in = 8'h51;
    char_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    check("ready_gated_by_clear", int'(char_ready), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    char_valid = 1'b0;
    push_clear();
    wait_idle(n, 3000);
    check("clear_fill_cycles", n, TOTAL);
    check_state("clear_idle");

    send(8'h58);
    @(posedge clk);
    #1;
    char_in = 8'h0A;
    char_valid = 1'b1;
    @(negedge clk);
    check("ready_lf", int'(char_ready), 1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    void'(model_byte(10));
    push_clear();
    repeat (5) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    wait_idle(n, 4000);
    check_state("clear_in_lineclr");

    for (int i = 0; i < 300; i++) begin
      int r, c;
      r = int'($urandom_range(0, 99));
      if (r < 70) c = int'($urandom_range(32, 126));
      else if (r < 80) c = 10;
      else if (r < 86) c = 13;
      else if (r < 93) c = 8;
      else if (r < 97) c = int'($urandom_range(0, 31));
      else if (r < 99) c = int'($urandom_range(127, 255));
      else c = 12;
      send(c);
    end

    // Reset during a fill restarts it from address 0.
    @(posedge clk);
    #1;
    char_in = 8'h0C;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    void'(model_byte(12));
    repeat (300) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    push_clear();
    @(negedge clk);
    check_reset_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle(n, 3000);
    check("refill_cycles", n, TOTAL);
    check_state("refill");
    send(8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Write-side companion to the character/font display path: accepts a byte stream of characters from the 6502 bus interface and writes character codes into the 50x37 text RAM that the letter generator reads.
- Maintains the cursor and handles the control codes CR, LF, BS and FF.
- Implements hardware scrolling with a row-offset register, which the display side uses to rotate rows.
- Owns the write port of the text RAM.

Parameters:
- COLS, 50, characters per row (800 px / 16)
- ROWS, 37, character rows (600 px / 16, truncated)
- ADDR_W, 11, text RAM address width (COLS*ROWS = 1850 <= 2048)
- BLANK, 8'h20, fill code used for clears and backspace

Ports:
- clk_in  input  1  pixel/system clock; all logic on posedge
- rst_n_in  input  1  synchronous active-low reset
- char_in  input  8  character or control byte
- char_valid_in  input  1  char_in valid
- char_ready_out  output  1  writer can accept a byte this cycle
- clear_in  input  1  one-cycle clear-screen request
- wr_en_out  output  1  text RAM write strobe
- wr_addr_out  output  ADDR_W  text RAM write address
- wr_data_out  output  8  text RAM write data
- cursor_col_out  output  6  logical cursor column, 0..COLS-1
- cursor_row_out  output  6  logical cursor row, 0..ROWS-1
- scroll_row_out  output  6  physical RAM row shown at the top of the screen
- busy_out  output  1  clear or row-clear in progress

Behaviour:
- One clock domain, clk_in. Reset is synchronous and active-low on rst_n_in.
- While rst_n_in=0: wr_en_out=0, wr_addr_out=0, wr_data_out=0, cursor=(0,0), scroll_row_out=0, char_ready_out=0, busy_out=1. The state machine is forced to CLEAR with fill index 0. Reset mid-operation aborts everything and restarts a full clear.
- Address mapping: phys_row = (cursor_row + scroll_row) mod ROWS; addr = phys_row*COLS + col. The mod is computed by compare-and-subtract; no divider.
- Text RAM write timing: all RAM-facing outputs are registered. A write is a single cycle with wr_en_out=1 and addr/data valid in that same cycle.
- CLEAR state:
  - Writes BLANK to addresses 0..COLS*ROWS-1, one per cycle: 1850 consecutive wr_en_out cycles.
  - Then resets cursor to (0,0) and scroll_row to 0, and goes to IDLE.
  - busy_out=1, char_ready_out=0 throughout.
- IDLE state:
  - char_ready_out=1, busy_out=0, wr_en_out=0.
  - clear_in=1 goes to CLEAR and takes priority over a simultaneous valid char, which is not accepted (ready drops the same cycle, combinationally gated by clear_in).
  - Otherwise, valid&&ready latches char_in and goes to EXEC.
- EXEC state: one cycle, char_ready_out=0. Action depends on the latched byte:
  - 0x20..0x7E: write the byte at the cursor. Then, if col<COLS-1, col+1 and return to IDLE; else col=0 and do NEWLINE.
  - 0x0D (CR): col=0, no write, IDLE.
  - 0x0A (LF): col unchanged, do NEWLINE.
  - 0x08 (BS): if col>0, col-1 and write BLANK at the new position. If col=0, no write and no move. Return to IDLE.
  - 0x0C (FF): go to CLEAR.
  - All other codes: accepted, no effect, IDLE.
- NEWLINE, decided in EXEC:
  - If row<ROWS-1: row+1.
  - Else: row stays at ROWS-1 and scroll_row = (scroll_row+1) mod ROWS.
  - Either way, go to LINECLR to blank the destination physical row.
- LINECLR state:
  - Writes BLANK to the COLS addresses of the new cursor row's physical row, col index 0..COLS-1, one per cycle.
  - busy_out=1, ready=0.
  - Then goes to IDLE, or to CLEAR if a clear_in pulse arrived during LINECLR. Any clear_in pulse seen while busy or in EXEC is latched and serviced on the next IDLE entry.
- Throughput: a printable character or control code costs 2 cycles (IDLE accept + EXEC). NEWLINE adds COLS cycles.
- Widths: col and row counters are 6-bit. The scroll increment wraps from ROWS-1 to 0, never reaching 37..63. The fill index is ADDR_W bits and terminates at COLS*ROWS-1.

Test Plan:
- Release reset -> exactly 1850 writes, addr 0..1849, data 0x20, on consecutive cycles; then char_ready_out=1, cursor (0,0), scroll 0.
- After init, send 'A' (0x41) -> one write addr 0 data 0x41 on the cycle after acceptance; cursor (1,0); ready deasserted for exactly 1 cycle.
- Send 50 printable bytes -> the 50th writes addr 49; cursor (0,1); 50 BLANK writes to addr 50..99 follow. The 51st byte writes addr 50.
- With the cursor on row 36, send LF -> scroll_row_out=1, cursor row stays 36; BLANK writes to addr 0..49. The next 'Z' writes addr 0 data 0x5A.
- At cursor (3,0) send BS -> write addr 2 data 0x20, cursor (2,0). At col 0, BS produces no write.
- Hold char_valid_in high and pulse clear_in in IDLE -> no char accepted; 1850 fill writes. A clear_in during LINECLR causes a full clear right after the row clear. Asserting rst_n_in=0 mid-fill restarts the fill from addr 0.
